// File: rtl/addsub_seq.sv
// addsub_seq: digit-serial two's-complement add/subtract unit with
// valid/ready handshakes on both sides. Each RUN cycle processes DIGIT bits,
// least-significant digit first. cout is the carry out of the MSB digit;
// for subtraction 1 means no borrow. ovf flags signed overflow.
// Optional feature: define ADDSUB_SAT_EN to saturate out on signed overflow;
// without it out is the wrapped modulo-2^WIDTH result.
module addsub_seq #(
  parameter int WIDTH = 20,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] a_sr;       // operand A, shifted right one digit per RUN edge
  logic [WIDTH-1:0] b_sr;       // operand B (inverted for subtract), shifted likewise
  logic [WIDTH-1:0] res_sr;     // result digits enter at the top, LSB digit first
  logic             carry;
  logic             sign_a;
  logic             sign_b;     // sign of the effective addend (~b for subtract)
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;
  logic [WIDTH-1:0] out_next;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(N - 1)) begin
          last       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One digit of the ripple sum plus the assembled result and overflow test.
  always_comb begin
    digit_sum = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};
    res_next  = (res_sr >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    ovf_next  = (sign_a == sign_b) && (res_next[WIDTH-1] != sign_a);
`ifdef ADDSUB_SAT_EN
    out_next  = ovf_next ? (sign_a ? MIN_NEG : MAX_POS) : res_next;
`else
    out_next  = res_next;
`endif
  end

  // Operand capture at accept, digit-serial processing in RUN, result load on the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the working registers are reset along with the outputs so a
    // reset mid-operation leaves no stale partial result behind.
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt    <= '0;
      out    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= mode ? ~b : b;
      res_sr <= '0;
      carry  <= mode;
      sign_a <= a[WIDTH-1];
      sign_b <= mode ? ~b[WIDTH-1] : b[WIDTH-1];
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> DIGIT;
      b_sr   <= b_sr >> DIGIT;
      res_sr <= res_next;
      carry  <= digit_sum[DIGIT];
      cnt    <= cnt + CW'(1);
      if (last) begin
        out  <= out_next;
        cout <= digit_sum[DIGIT];
        ovf  <= ovf_next;
      end
    end
  end

endmodule
